// File: rtl/mc_control_if.sv
// Bundle of signals between the multicycle main control FSM and the MIPS datapath.
// The controller uses the master side; the datapath/memory uses the slave side.
interface mc_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, aluop, pc_source, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, aluop, pc_source, illegal_op, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable, stalling on the memory ready handshake.
module mc_control #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       ready;
    logic       pc_write, branch;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, aluop, pc_source;

    assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        pc_source  = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
                state_d   = ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is precomputed here so BEQEX can use ALUOut.
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                state_d   = RTYPEWB;
            end
            RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_source = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JEX: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset gates every output combinationally so nothing fires while rst_n is low.
    assign bus.pc_en      = rst_n & (pc_write | (branch & bus.zero));
    assign bus.iord       = rst_n & iord;
    assign bus.mem_read   = rst_n & mem_read;
    assign bus.mem_write  = rst_n & mem_write;
    assign bus.ir_write   = rst_n & ir_write;
    assign bus.reg_dst    = rst_n & reg_dst;
    assign bus.mem_to_reg = rst_n & mem_to_reg;
    assign bus.reg_write  = rst_n & reg_write;
    assign bus.alu_src_a  = rst_n & alu_src_a;
    assign bus.alu_src_b  = {2{rst_n}} & alu_src_b;
    assign bus.aluop      = {2{rst_n}} & aluop;
    assign bus.pc_source  = {2{rst_n}} & pc_source;
    assign bus.illegal_op = rst_n & illegal_op;
    assign bus.state      = {4{rst_n}} & state_q;
endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: an instruction-path model checks every output each cycle,
// while directed instruction sequences pin literal state and strobe expectations.
module tb_mc_control;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_if bus();

    mc_control #(.USE_MEM_READY(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Static outputs per phase: {iord, mem_read, mem_write, reg_dst, mem_to_reg,
    // reg_write, alu_src_a, alu_src_b, aluop, pc_source}
    function automatic logic [12:0] phase_outputs(input int s);
        case (s)
            0:  return 13'b0_1_0_0_0_0_0_01_00_00;
            1:  return 13'b0_0_0_0_0_0_0_11_00_00;
            2:  return 13'b0_0_0_0_0_0_1_10_00_00;
            3:  return 13'b1_1_0_0_0_0_0_00_00_00;
            4:  return 13'b0_0_0_0_1_1_0_00_00_00;
            5:  return 13'b1_0_1_0_0_0_0_00_00_00;
            6:  return 13'b0_0_0_0_0_0_1_00_10_00;
            7:  return 13'b0_0_0_1_0_1_0_00_00_00;
            8:  return 13'b0_0_0_0_0_0_1_00_01_01;
            9:  return 13'b0_0_0_0_0_0_1_10_00_00;
            10: return 13'b0_0_0_0_0_1_0_00_00_00;
            11: return 13'b0_0_0_0_0_0_0_00_00_10;
            default: return 13'b0;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_ADDI || op == OP_J;
    endfunction

    // Model: current phase plus the queue of phases the decoded instruction still owes.
    int          mst = 0;
    int          path[$];
    logic [19:0] m_exp, m_act;
    logic        m_rdy;

    always @(negedge clk) begin
        m_rdy = bus.mem_ready;
        m_act = {bus.pc_en, bus.illegal_op, bus.ir_write, bus.iord, bus.mem_read,
                 bus.mem_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                 bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.pc_source, bus.state};
        if (!rst_n) begin
            mst = 0;
            path.delete();
            m_exp = 20'b0;
        end else begin
            m_exp = {(mst == 0 && m_rdy) || mst == 11 || (mst == 8 && bus.zero),
                     mst == 1 && !legal(bus.opcode),
                     mst == 0 && m_rdy,
                     phase_outputs(mst), 4'(mst)};
        end
        check("cycle_outputs", 32'(m_act), 32'(m_exp));
        if (rst_n) begin
            if ((mst == 0 || mst == 3 || mst == 5) && !m_rdy) begin
                mst = mst;
            end else if (mst == 0) begin
                mst = 1;
            end else begin
                if (mst == 1) begin
                    case (bus.opcode)
                        OP_LW:   path = '{2, 3, 4};
                        OP_SW:   path = '{2, 5};
                        OP_R:    path = '{6, 7};
                        OP_BEQ:  path = '{8};
                        OP_ADDI: path = '{9, 10};
                        OP_J:    path = '{11};
                        default: path.delete();
                    endcase
                end
                mst = (path.size() > 0) ? path.pop_front() : 0;
            end
        end
    end

    // One cycle: drive inputs, check state (and optional pc_en/illegal_op) mid-cycle.
    task automatic step(input logic [5:0] op, input logic rdy, input logic z,
                        input int exp_st, input int exp_pc = -1, input int exp_ill = -1);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = z;
        @(negedge clk);
        check("state", 32'(bus.state), 32'(exp_st));
        if (exp_pc >= 0)  check("pc_en", 32'(bus.pc_en), 32'(exp_pc));
        if (exp_ill >= 0) check("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.opcode    = OP_LW;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_state", 32'(bus.state), 32'd0);
            check("rst_mem_read", 32'(bus.mem_read), 32'd0);
            check("rst_ir_write", 32'(bus.ir_write), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("fetch_state", 32'(bus.state), 32'd0);
        check("fetch_mem_read", 32'(bus.mem_read), 32'd1);
        check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        check("fetch_pc_en", 32'(bus.pc_en), 32'd1);
        @(posedge clk);
        #1;
        // lw, no waits: 0,1,2,3,4
        step(OP_LW, 1, 0, 1);
        step(OP_LW, 1, 0, 2);
        step(OP_LW, 1, 0, 3);
        step(OP_LW, 1, 0, 4);
        // sw with two wait cycles in MEMWR
        step(OP_SW, 1, 0, 0);
        step(OP_SW, 1, 0, 1);
        step(OP_SW, 1, 0, 2);
        step(OP_SW, 0, 0, 5);
        step(OP_SW, 0, 0, 5);
        step(OP_SW, 1, 0, 5);
        // R-type
        step(OP_R, 1, 0, 0);
        step(OP_R, 1, 0, 1);
        step(OP_R, 1, 0, 6);
        step(OP_R, 1, 0, 7);
        // beq taken then not taken
        step(OP_BEQ, 1, 1, 0);
        step(OP_BEQ, 1, 1, 1);
        step(OP_BEQ, 1, 1, 8, 1);
        step(OP_BEQ, 1, 0, 0);
        step(OP_BEQ, 1, 0, 1);
        step(OP_BEQ, 1, 0, 8, 0);
        // addi, j
        step(OP_ADDI, 1, 0, 0);
        step(OP_ADDI, 1, 0, 1);
        step(OP_ADDI, 1, 0, 9);
        step(OP_ADDI, 1, 0, 10);
        step(OP_J, 1, 0, 0);
        step(OP_J, 1, 0, 1, 0);
        step(OP_J, 1, 0, 11, 1);
        // undefined opcode: two cycles, pulse in DECODE only
        step(OP_BAD, 1, 0, 0, 1, 0);
        step(OP_BAD, 1, 0, 1, 0, 1);
        // fetch wait, then lw stalled in MEMRD and reset mid-wait
        step(OP_LW, 0, 0, 0, 0, 0);
        step(OP_LW, 1, 0, 0, 1);
        step(OP_LW, 1, 0, 1);
        step(OP_LW, 1, 0, 2);
        step(OP_LW, 0, 0, 3);
        step(OP_LW, 0, 0, 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state), 32'd0);
        check("async_rst_mem_read", 32'(bus.mem_read), 32'd0);
        step(OP_LW, 1, 0, 0, 0);
        step(OP_LW, 1, 0, 0, 0);
        rst_n = 1'b1;
        step(OP_R, 1, 0, 0, 1);
        step(OP_R, 1, 0, 1);
        step(OP_R, 1, 0, 6);
        step(OP_R, 1, 0, 7);
        step(OP_R, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
